// File: rtl/flr_csr_pkg.sv
// Shared types and constants for the FLR CSR responder.
package flr_csr_pkg;

    localparam logic [15:0] DFH_OFS     = 16'h0000;
    localparam logic [15:0] SCRATCH_OFS = 16'h0008;
    localparam logic [15:0] TESTPAD_OFS = 16'h0028;
    localparam logic [63:0] ERR_DATA    = 64'hFFFF_FFFF_FFFF_FFFF;

    // Response tags are carried at this width; TAG_W of the top must not exceed it.
    localparam int RSP_TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        FLR_IDLE  = 2'd0,
        FLR_DRAIN = 2'd1,
        FLR_CLEAR = 2'd2,
        FLR_ACK   = 2'd3
    } flr_state_e;

    typedef struct packed {
        logic [63:0]              data;
        logic [RSP_TAG_MAX_W-1:0] tag;
        logic                     err;
    } rsp_t;

    // 64-bit accesses must be 8-byte aligned.
    function automatic logic is_aligned(input logic [2:0] addr_lsb);
        return (addr_lsb == 3'b000);
    endfunction

endpackage

// File: rtl/flr_csr_rsp_fifo.sv
// Two-entry response FIFO; entry 0 is always the head presented to the consumer.
module flr_csr_rsp_fifo
    import flr_csr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rsp_t       push_data,
    input  logic       pop,
    output rsp_t       head,
    output logic [1:0] count
);

    rsp_t       ent0_q, ent0_d;
    rsp_t       ent1_q, ent1_d;
    logic [1:0] cnt_q, cnt_d;
    logic       push_s;
    logic       pop_s;

    // Next-state of the shift-style storage; a full FIFO ignores push, an empty one ignores pop.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        push_s = push && (cnt_q != 2'd2);
        pop_s  = pop && (cnt_q != 2'd0);
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = push_data;
                end else begin
                    ent1_d = push_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with one entry: the new entry replaces the departing head.
                ent0_d = push_data;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head  = ent0_q;
    assign count = cnt_q;

endmodule

// File: rtl/flr_csr_responder.sv
// MMIO responder for the PCIe-subsystem CSR window with per-function FLR handling.
module flr_csr_responder
    import flr_csr_pkg::*;
#(
    parameter int          NUM_FUNCS = 4,
    parameter logic [63:0] DFH_VALUE = 64'h3000000010000020,
    parameter logic [19:0] WIN_BASE  = 20'h10000,
    parameter int          TAG_W     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [3:0]       req_func,
    input  logic [19:0]      req_addr,
    input  logic [63:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    input  logic             flr_req_valid,
    output logic             flr_req_ready,
    input  logic [3:0]       flr_func,
    output logic             flr_ack
);

    flr_state_e  state_q, state_d;
    logic [3:0]  flr_func_q, flr_func_d;
    logic        flr_ack_q, flr_ack_d;
    logic        flr_req_ready_q, flr_req_ready_d;
    logic        req_ready_q, req_ready_d;
    logic [63:0] scratch_q [NUM_FUNCS];
    logic [63:0] scratch_d [NUM_FUNCS];
    logic [63:0] testpad_q [NUM_FUNCS];
    logic [63:0] testpad_d [NUM_FUNCS];

    logic        accept_s;
    logic        pop_s;
    logic        push_s;
    logic        req_err_s;
    logic [63:0] rd_data_s;
    logic [63:0] sel_scratch_s;
    logic [63:0] sel_testpad_s;
    logic [15:0] offset_s;
    rsp_t        push_data_s;
    rsp_t        fifo_head_s;
    logic [1:0]  fifo_cnt_s;
    logic [1:0]  fifo_cnt_next_s;
    logic        rsp_tag_unused_s;

    assign accept_s = req_valid && req_ready_q;
    assign pop_s    = rsp_valid && rsp_ready;
    assign offset_s = req_addr[15:0];

    // Decode, error classification and read-data selection from the current register values.
    always_comb begin
        sel_scratch_s = 64'd0;
        sel_testpad_s = 64'd0;
        for (int i = 0; i < NUM_FUNCS; i++) begin
            if (req_func == 4'(i)) begin
                sel_scratch_s = scratch_q[i];
                sel_testpad_s = testpad_q[i];
            end else begin
                sel_scratch_s = sel_scratch_s;
                sel_testpad_s = sel_testpad_s;
            end
        end
        req_err_s = (req_addr[19:16] != WIN_BASE[19:16])
                 || !is_aligned(req_addr[2:0])
                 || ({28'd0, req_func} >= 32'(NUM_FUNCS))
                 || (((state_q == FLR_DRAIN) || (state_q == FLR_CLEAR)) && (req_func == flr_func_q));
        case (offset_s)
            DFH_OFS:     rd_data_s = DFH_VALUE;
            SCRATCH_OFS: rd_data_s = sel_scratch_s;
            TESTPAD_OFS: rd_data_s = sel_testpad_s;
            default:     rd_data_s = 64'd0;
        endcase
        push_s           = accept_s && (!req_write || req_err_s);
        push_data_s.data = req_err_s ? ERR_DATA : rd_data_s;
        push_data_s.tag  = RSP_TAG_MAX_W'(req_tag);
        push_data_s.err  = req_err_s;
    end

    // Occupancy the FIFO will have next cycle, used for ready and drain decisions.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_next_s = fifo_cnt_s + 2'd1;
            2'b01:   fifo_cnt_next_s = fifo_cnt_s - 2'd1;
            default: fifo_cnt_next_s = fifo_cnt_s;
        endcase
    end

    // Register-file next state: accepted good writes, then the FLR clear of the latched function.
    always_comb begin
        scratch_d = scratch_q;
        testpad_d = testpad_q;
        for (int i = 0; i < NUM_FUNCS; i++) begin
            if (accept_s && req_write && !req_err_s && (req_func == 4'(i))) begin
                if (offset_s == SCRATCH_OFS) begin
                    scratch_d[i] = req_wdata;
                end else if (offset_s == TESTPAD_OFS) begin
                    testpad_d[i] = req_wdata;
                end else begin
                    scratch_d[i] = scratch_d[i];
                end
            end else begin
                scratch_d[i] = scratch_d[i];
            end
            if ((state_q == FLR_CLEAR) && (flr_func_q == 4'(i))) begin
                scratch_d[i] = 64'd0;
                testpad_d[i] = 64'd0;
            end else begin
                testpad_d[i] = testpad_d[i];
            end
        end
    end

    // FLR sequencing: IDLE -> DRAIN -> CLEAR -> ACK, with registered handshake outputs.
    always_comb begin
        state_d    = state_q;
        flr_func_d = flr_func_q;
        case (state_q)
            FLR_IDLE: begin
                if (flr_req_valid && flr_req_ready_q) begin
                    flr_func_d = flr_func;
                    if ({28'd0, flr_func} >= 32'(NUM_FUNCS)) begin
                        state_d = FLR_ACK;
                    end else begin
                        state_d = FLR_DRAIN;
                    end
                end else begin
                    state_d = FLR_IDLE;
                end
            end
            FLR_DRAIN: begin
                if (fifo_cnt_next_s == 2'd0) begin
                    state_d = FLR_CLEAR;
                end else begin
                    state_d = FLR_DRAIN;
                end
            end
            FLR_CLEAR: state_d = FLR_ACK;
            FLR_ACK:   state_d = FLR_IDLE;
            default:   state_d = FLR_IDLE;
        endcase
        flr_ack_d       = (state_d == FLR_ACK);
        flr_req_ready_d = (state_d == FLR_IDLE);
        req_ready_d     = (fifo_cnt_next_s != 2'd2) && (state_d != FLR_CLEAR);
    end

    // FLR state machine and handshake output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= FLR_IDLE;
            flr_func_q      <= 4'd0;
            flr_ack_q       <= 1'b0;
            flr_req_ready_q <= 1'b1;
            req_ready_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            flr_func_q      <= flr_func_d;
            flr_ack_q       <= flr_ack_d;
            flr_req_ready_q <= flr_req_ready_d;
            req_ready_q     <= req_ready_d;
        end
    end

    // Per-function SCRATCHPAD and TESTPAD storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FUNCS; i++) begin
                scratch_q[i] <= 64'd0;
                testpad_q[i] <= 64'd0;
            end
        end else begin
            scratch_q <= scratch_d;
            testpad_q <= testpad_d;
        end
    end

    flr_csr_rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .count     (fifo_cnt_s)
    );

    // Tag bits above TAG_W are always zero and are intentionally dropped.
    assign rsp_tag_unused_s = ^fifo_head_s.tag;

    assign rsp_valid     = (fifo_cnt_s != 2'd0);
    assign rsp_data      = fifo_head_s.data;
    assign rsp_tag       = fifo_head_s.tag[TAG_W-1:0];
    assign rsp_err       = fifo_head_s.err;
    assign req_ready     = req_ready_q;
    assign flr_req_ready = flr_req_ready_q;
    assign flr_ack       = flr_ack_q;

endmodule

// File: tb/tb_flr_csr_responder.sv
// Scoreboard bench for flr_csr_responder.
module tb_flr_csr_responder;

    localparam logic [63:0] DFH = 64'h3000000010000020;
    localparam logic [63:0] ERR = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] data;
        logic [9:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_func;
    logic [19:0] req_addr;
    logic [63:0] req_wdata;
    logic [9:0]  req_tag;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_data;
    logic [9:0]  rsp_tag;
    logic        flr_req_valid, flr_req_ready, flr_ack;
    logic [3:0]  flr_func;

    exp_t        sb_q[$];
    logic [63:0] m_scr [4];
    logic [63:0] m_tp  [4];
    logic        flr_busy;
    logic [3:0]  busy_func;
    int          chk_cnt = 0;
    int          err_cnt = 0;
    int          ack_cnt = 0;

    flr_csr_responder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .flr_req_valid(flr_req_valid), .flr_req_ready(flr_req_ready),
        .flr_func(flr_func), .flr_ack(flr_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_err(input logic [3:0] f, input logic [19:0] a);
        return (a[19:16] != 4'h1) || (a[2:0] != 3'd0) || (f >= 4'd4) || (flr_busy && (f == busy_func));
    endfunction

    function automatic logic [63:0] exp_rd(input logic [3:0] f, input logic [19:0] a);
        case (a[15:0])
            16'h0000: return DFH;
            16'h0008: return m_scr[f[1:0]];
            16'h0028: return m_tp[f[1:0]];
            default:  return 64'd0;
        endcase
    endfunction

    // Scoreboard: compare each consumed response with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t x;
                x = sb_q.pop_front();
                check("rsp_data", rsp_data, x.data);
                check("rsp_tag", 64'(rsp_tag), 64'(x.tag));
                check("rsp_err", 64'(rsp_err), 64'(x.err));
            end
        end
        if (rst_n && flr_ack) ack_cnt++;
    end

    // Drive one request (called right after a clock edge) and record its expected response.
    task automatic send(input logic wr, input logic [3:0] f, input logic [19:0] a,
                        input logic [63:0] wd, input logic [9:0] tg);
        int   n = 0;
        exp_t x;
        logic e;
        req_valid = 1'b1; req_write = wr; req_func = f; req_addr = a; req_wdata = wd; req_tag = tg;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("req_accept", 64'(req_ready), 64'd1);
        if (req_ready) begin
            e = exp_err(f, a);
            if (!wr || e) begin
                x.data = e ? ERR : exp_rd(f, a);
                x.tag  = tg;
                x.err  = e;
                sb_q.push_back(x);
            end
            if (wr && !e) begin
                if (a[15:0] == 16'h0008) m_scr[f[1:0]] = wd;
                if (a[15:0] == 16'h0028) m_tp[f[1:0]] = wd;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic flr(input logic [3:0] f);
        int n = 0;
        flr_req_valid = 1'b1; flr_func = f;
        while (!flr_req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("flr_accept", 64'(flr_req_ready), 64'd1);
        if (flr_req_ready) begin
            if (f < 4'd4) begin
                flr_busy = 1'b1; busy_func = f;
            end
            @(posedge clk); #1;
        end
        flr_req_valid = 1'b0;
    endtask

    task automatic wait_ack();
        int   n = 0;
        logic seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk); n++;
            if (flr_ack) begin
                seen = 1'b1;
                check("ack_fifo_empty", 64'(rsp_valid), 64'd0);
            end
        end
        check("flr_ack_seen", 64'(seen), 64'd1);
        @(negedge clk);
        check("ack_pulse", 64'(flr_ack), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk); n++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_func = 4'd0; req_addr = 20'd0;
        req_wdata = 64'd0; req_tag = 10'd0; rsp_ready = 1'b1; flr_req_valid = 1'b0; flr_func = 4'd0;
        flr_busy = 1'b0; busy_func = 4'd0;
        for (int i = 0; i < 4; i++) begin m_scr[i] = 64'd0; m_tp[i] = 64'd0; end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_flr_ready", 64'(flr_req_ready), 64'd1);
        check("rst_flr_ack", 64'(flr_ack), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_first", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check("req_ready_after", 64'(req_ready), 64'd1);

        // Scratchpad write/read with one-cycle read latency
        send(1'b1, 4'd0, 20'h10008, 64'hDEADBEEF_CAFEF00D, 10'd0);
        send(1'b0, 4'd0, 20'h10008, 64'd0, 10'd5);
        check("rd_latency", 64'(rsp_valid), 64'd1);
        drain();

        // DFH is read-only
        send(1'b0, 4'd2, 20'h10000, 64'd0, 10'd6);
        send(1'b1, 4'd2, 20'h10000, 64'd0, 10'd7);
        send(1'b0, 4'd2, 20'h10000, 64'd0, 10'd8);
        drain();

        // Error cases and unmapped aligned offset
        send(1'b0, 4'd0, 20'h10004, 64'd0, 10'd9);
        send(1'b0, 4'd0, 20'h20008, 64'd0, 10'd10);
        send(1'b1, 4'd0, 20'h20008, 64'h1234, 10'd11);
        send(1'b0, 4'd0, 20'h10008, 64'd0, 10'd12);
        send(1'b0, 4'd0, 20'h10010, 64'd0, 10'd13);
        send(1'b0, 4'd5, 20'h10008, 64'd0, 10'd14);
        drain();

        // FLR of func1 while responses are stalled
        send(1'b1, 4'd1, 20'h10028, 64'h55, 10'd0);
        send(1'b1, 4'd2, 20'h10028, 64'hAA, 10'd0);
        send(1'b1, 4'd1, 20'h10008, 64'h77, 10'd0);
        rsp_ready = 1'b0;
        send(1'b0, 4'd2, 20'h10028, 64'd0, 10'd30);
        flr(4'd1);
        send(1'b0, 4'd1, 20'h10028, 64'd0, 10'd31);
        repeat (5) begin
            @(negedge clk);
            check("flr_ack_early", 64'(flr_ack), 64'd0);
            check("flr_ready_busy", 64'(flr_req_ready), 64'd0);
            check("req_ready_full", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_ack();
        m_scr[1] = 64'd0; m_tp[1] = 64'd0; flr_busy = 1'b0;
        drain();
        send(1'b0, 4'd1, 20'h10028, 64'd0, 10'd32);
        send(1'b0, 4'd1, 20'h10008, 64'd0, 10'd33);
        send(1'b0, 4'd2, 20'h10028, 64'd0, 10'd34);
        drain();

        // FLR of a nonexistent function acknowledges without touching registers
        flr(4'd9);
        wait_ack();
        send(1'b0, 4'd2, 20'h10028, 64'd0, 10'd35);
        drain();

        // Back-to-back reads against a stalled consumer
        rsp_ready = 1'b0;
        send(1'b0, 4'd0, 20'h10008, 64'd0, 10'd20);
        send(1'b0, 4'd2, 20'h10028, 64'd0, 10'd21);
        check("req_ready_two", 64'(req_ready), 64'd0);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
            send(1'b0, 4'd1, 20'h10028, 64'd0, 10'd22);
        join
        drain();

        // Reset during DRAIN
        send(1'b1, 4'd0, 20'h10008, 64'h11, 10'd0);
        send(1'b1, 4'd3, 20'h10028, 64'h22, 10'd0);
        rsp_ready = 1'b0;
        send(1'b0, 4'd3, 20'h10028, 64'd0, 10'd40);
        flr(4'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        a0 = ack_cnt;
        @(posedge clk); #1 rst_n = 1'b1;
        sb_q.delete();
        for (int i = 0; i < 4; i++) begin m_scr[i] = 64'd0; m_tp[i] = 64'd0; end
        flr_busy = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_flr_ready", 64'(flr_req_ready), 64'd1);
        repeat (6) @(negedge clk);
        check("mid_rst_no_ack", 64'(ack_cnt), 64'(a0));
        @(posedge clk); #1 rsp_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            send(1'b0, 4'(f), 20'h10008, 64'd0, 10'(50 + f));
            send(1'b0, 4'(f), 20'h10028, 64'd0, 10'(60 + f));
        end
        drain();
        check("mid_rst_no_ack_end", 64'(ack_cnt), 64'(a0));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
